stp_watch_ctrl: RTL and testbench
=================================

# stp_watch_ctrl

Control and sequencing block for the stopwatch timer. Turns debounced start/stop, reset and lap button pulses into the stopwatch run state. Generates the 1 Hz seconds tick and the cascaded `count_up_min` / `count_up_hr` enables, using the current second and minute values fed back from the counters. Also drives the counters' `stop` / `rst_counters` clears and a display-hold flag for lap readout.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per second; must be ≥ 2.
- `CLK`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_start_stop`  in  1  single-cycle pulse, already synchronized and debounced.
- `btn_reset`  in  1  single-cycle pulse, already synchronized and debounced.
- `btn_lap`  in  1  single-cycle pulse, already synchronized and debounced.
- `sec_val`  in  8  current seconds counter value, 0–59.
- `min_val`  in  8  current minutes counter value, 0–59.
- `count_up_sec`  out  1  one-cycle seconds increment enable.
- `count_up_min`  out  1  one-cycle minutes increment enable.
- `count_up_hr`  out  1  one-cycle hours increment enable.
- `stop`  out  1  holds all counters at zero.
- `rst_counters`  out  1  one-cycle clear pulse to all counters.
- `disp_hold`  out  1  display shows latched lap value.
- `state`  out  2  current FSM state, for status LEDs and debug.

## Operation
**FSM states:** IDLE=0, RUN=1, PAUSE=2, LAP=3. LAP means running with the display frozen.

**Transitions** (one per rising edge, evaluated in the order listed):
- IDLE: `btn_start_stop` → RUN. Lap and reset are ignored.
- RUN: `btn_start_stop` → PAUSE; else `btn_lap` → LAP. Reset is ignored.
- LAP: `btn_start_stop` → PAUSE with `disp_hold` cleared; else `btn_lap` → RUN. Reset is ignored.
- PAUSE: `btn_reset` → IDLE, taking priority over `btn_start_stop`; else `btn_start_stop` → RUN. Lap is ignored.

**Outputs:**
- `stop` = 1 exactly while state is IDLE (decoded from the state register).
- `rst_counters` is a registered one-cycle pulse, asserted in the cycle after a PAUSE→IDLE transition.
- `disp_hold` = 1 exactly while state is LAP.

**Prescaler:**
- Unsigned counter, width $clog2(TICK_DIV), range 0..TICK_DIV-1.
- Cleared to 0 in IDLE.
- Increments in RUN and LAP and wraps at TICK_DIV-1.
- Holds its value in PAUSE, so elapsed time resumes exactly.

**Tick cascade:**
- `count_up_sec` is registered: it goes high for the one cycle after the prescaler equals TICK_DIV-1 in RUN or LAP.
- A tick whose terminal count is reached on the same edge as a pause command is still issued.
- `count_up_min` = `count_up_sec` & (`sec_val` == 59), combinational. During the tick cycle `sec_val` still holds its pre-increment value.
- `count_up_hr` = `count_up_min` & (`min_val` == 59), combinational.
- There is no hour rollover logic here; the hours counter wraps 23→0 itself.

**Reset:** asynchronous assertion of `rst_n` forces IDLE, prescaler = 0, and all outputs to their reset values. This applies mid-RUN as well.

## Timing
**Reset values:**
- `state` = 0.
- `stop` = 1.
- `rst_counters`, `disp_hold`, `count_up_sec`, `count_up_min`, `count_up_hr` all = 0.

**Latencies:**
- Button pulse in cycle N → new state visible in cycle N+1.
- Start in cycle N → prescaler = 0 in cycle N+1 → first `count_up_sec` in cycle N+1+TICK_DIV.
- Afterwards, ticks are exactly TICK_DIV cycles apart while running.
- `count_up_min` and `count_up_hr` are in the same cycle as their `count_up_sec`.
- `rst_counters` is high in cycle N+1 after a reset press in cycle N, alongside `stop` = 1.

**Simultaneous inputs:** the priorities listed under Operation apply; all other combinations fall through.

**Back-to-back presses:** presses on consecutive cycles are each honoured.

## Structure
- Package `stp_pkg`: state encoding constants, `SEC_MAX` = 59, `MIN_MAX` = 59.
- Sub-module `stp_prescaler`: counter with `clr` and `en` inputs and a registered `tick` output.
- FSM, output decode and cascade logic live in the top module.

## Test plan
All scenarios use TICK_DIV = 4.

1. **Reset values:** reset → `stop`=1, `state`=0, no ticks for 20 cycles. Then start pulse → `state`=1 next cycle; `count_up_sec` pulses every 4 cycles, first one 5 cycles after the start edge.
2. **Cascade:** `sec_val`=59, `min_val`=59 at a tick → `count_up_sec`, `count_up_min`, `count_up_hr` all high in the same cycle. With `sec_val`=58 → only `count_up_sec`.
3. **Pause and resume:** pause with prescaler = 2, wait 10 cycles, resume → next tick exactly 2 cycles after the resume edge (prescaler 2→3, then tick). No ticks while paused.
4. **Reset handling:** reset pulse in RUN → ignored. Reset in PAUSE together with `btn_start_stop` → IDLE, one-cycle `rst_counters`, `stop`=1.
5. **Lap:** lap in RUN → `disp_hold`=1 and ticks continue. Lap again → `disp_hold`=0. Lap, then start/stop → PAUSE with `disp_hold`=0.
6. **Reset mid-run:** `rst_n` low mid-RUN, asynchronously between edges → outputs return to reset values immediately and the prescaler restarts from 0 after the next start.

Source files
------------

// File: rtl/stp_watch_ctrl_pkg.sv
// Shared constants for the stopwatch controller: state encoding and counter limits.
package stp_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_LAP   = 2'd3;

  localparam logic [7:0] SEC_MAX = 8'd59;
  localparam logic [7:0] MIN_MAX = 8'd59;

  // Time advances in both RUN and LAP; LAP only freezes the display.
  function automatic logic is_running(input logic [1:0] st);
    return (st == ST_RUN) || (st == ST_LAP);
  endfunction

endpackage

// File: rtl/stp_watch_ctrl_if.sv
// Bundle between the stopwatch controller and its buttons/counters/display.
interface stp_watch_ctrl_if;

  logic       btn_start_stop;
  logic       btn_reset;
  logic       btn_lap;
  logic [7:0] sec_val;
  logic [7:0] min_val;

  logic       count_up_sec;
  logic       count_up_min;
  logic       count_up_hr;
  logic       stop;
  logic       rst_counters;
  logic       disp_hold;
  logic [1:0] state;

  modport master (
    input  btn_start_stop, btn_reset, btn_lap, sec_val, min_val,
    output count_up_sec, count_up_min, count_up_hr, stop, rst_counters,
           disp_hold, state
  );

  modport slave (
    output btn_start_stop, btn_reset, btn_lap, sec_val, min_val,
    input  count_up_sec, count_up_min, count_up_hr, stop, rst_counters,
           disp_hold, state
  );

endinterface

// File: rtl/stp_watch_ctrl_prescaler.sv
// Seconds prescaler: counts 0..TICK_DIV-1 while enabled, holds otherwise,
// and emits a registered one-cycle tick after the terminal count.
module stp_prescaler #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned W = $clog2(TICK_DIV);
  localparam logic [W-1:0] TC = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = en_i && (cnt_q == TC);
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == TC) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/stp_watch_ctrl.sv
// Stopwatch sequencing: button FSM, seconds tick generation and min/hr cascade.
//
//   state | meaning
//   IDLE  | counters held at zero, prescaler cleared
//   RUN   | time advancing, live display
//   PAUSE | time frozen, prescaler holds its phase
//   LAP   | time advancing, display holds lap value
module stp_watch_ctrl
  import stp_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic              CLK,
  input  logic              rst_n,
  stp_watch_ctrl_if.master  bus
);

  logic [1:0] state_q, state_d;
  logic       rst_cnt_q, rst_cnt_d;
  logic       tick;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.btn_start_stop) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.btn_start_stop)  state_d = ST_PAUSE;
        else if (bus.btn_lap)    state_d = ST_LAP;
      end
      ST_LAP: begin
        if (bus.btn_start_stop)  state_d = ST_PAUSE;
        else if (bus.btn_lap)    state_d = ST_RUN;
      end
      ST_PAUSE: begin
        if (bus.btn_reset)            state_d = ST_IDLE;
        else if (bus.btn_start_stop)  state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rst_cnt_d = (state_q == ST_PAUSE) && bus.btn_reset;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rst_cnt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end

  // Enable follows the current state, so a terminal count on a pause edge still ticks.
  stp_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (CLK),
    .rst_n  (rst_n),
    .clr_i  (state_q == ST_IDLE),
    .en_i   (is_running(state_q)),
    .tick_o (tick)
  );

  assign bus.count_up_sec = tick;
  assign bus.count_up_min = tick && (bus.sec_val == SEC_MAX);
  assign bus.count_up_hr  = bus.count_up_min && (bus.min_val == MIN_MAX);
  assign bus.stop         = (state_q == ST_IDLE);
  assign bus.disp_hold    = (state_q == ST_LAP);
  assign bus.rst_counters = rst_cnt_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_stp_watch_ctrl.sv
// Self-checking bench for stp_watch_ctrl: directed scenarios with literal
// expectations plus a randomized run compared every cycle against a behavioural model.
module tb_stp_watch_ctrl;

  localparam int TD = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stp_watch_ctrl_if bus ();

  stp_watch_ctrl #(.TICK_DIV(TD)) dut (
    .CLK   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Model: mode number plus total running cycles since leaving IDLE;
  // a second elapses each time that running total reaches a multiple of TD.
  int m_state = 0;
  int m_run   = 0;
  bit m_tick  = 1'b0;
  bit m_rstc  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    bit s, r, l, running;
    if (!rst_n) begin
      m_state = 0;
      m_run   = 0;
      m_tick  = 1'b0;
      m_rstc  = 1'b0;
    end else begin
      s = bus.btn_start_stop;
      r = bus.btn_reset;
      l = bus.btn_lap;
      running = (m_state == 1) || (m_state == 3);
      m_tick  = running && (((m_run + 1) % TD) == 0);
      if (running) m_run = m_run + 1;
      else if (m_state == 0) m_run = 0;
      m_rstc = (m_state == 2) && r;
      case (m_state)
        0: if (s) m_state = 1;
        1: if (s) m_state = 2; else if (l) m_state = 3;
        3: if (s) m_state = 2; else if (l) m_state = 1;
        2: if (r) m_state = 0; else if (s) m_state = 1;
        default: m_state = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [7:0] act, exp;
    logic       emin;
    emin = m_tick && (bus.sec_val == 8'd59);
    act = {bus.state, bus.stop, bus.disp_hold, bus.rst_counters,
           bus.count_up_sec, bus.count_up_min, bus.count_up_hr};
    exp = {2'(m_state), (m_state == 0), (m_state == 3), m_rstc,
           m_tick, emin, emin && (bus.min_val == 8'd59)};
    check("cycle_cmp", int'(act), int'(exp));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic s, input logic r, input logic l);
    bus.btn_start_stop = s;
    bus.btn_reset      = r;
    bus.btn_lap        = l;
    step();
    bus.btn_start_stop = 1'b0;
    bus.btn_reset      = 1'b0;
    bus.btn_lap        = 1'b0;
  endtask

  task automatic wait_tick(output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bus.count_up_sec) begin
        n = i;
        break;
      end
    end
  endtask

  function automatic int casc();
    return int'({bus.count_up_sec, bus.count_up_min, bus.count_up_hr});
  endfunction

  initial begin
    int ticks, first, n;
    bus.btn_start_stop = 1'b0;
    bus.btn_reset      = 1'b0;
    bus.btn_lap        = 1'b0;
    bus.sec_val        = 8'd0;
    bus.min_val        = 8'd0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_state", int'(bus.state), 0);
    check("reset_stop", int'(bus.stop), 1);
    ticks = 0;
    repeat (20) begin
      step();
      ticks += int'(bus.count_up_sec);
    end
    check("idle_no_ticks", ticks, 0);

    press(1'b1, 1'b0, 1'b0);
    check("start_state", int'(bus.state), 1);
    first = -1;
    ticks = 0;
    for (int i = 2; i <= 12; i++) begin
      step();
      if (bus.count_up_sec) begin
        ticks++;
        if (first < 0) first = i;
      end
    end
    check("first_tick_cycle", first, 5);
    check("tick_count", ticks, 2);

    bus.sec_val = 8'd59;
    bus.min_val = 8'd59;
    wait_tick(n);
    check("casc_wait", n, 1);
    check("casc_all", casc(), 7);
    bus.sec_val = 8'd58;
    wait_tick(n);
    check("tick_period", n, 4);
    check("casc_sec_only", casc(), 4);
    bus.sec_val = 8'd59;
    bus.min_val = 8'd10;
    wait_tick(n);
    check("casc_sec_min", casc(), 6);
    bus.sec_val = 8'd0;
    bus.min_val = 8'd0;

    step();
    press(1'b1, 1'b0, 1'b0);
    check("pause_state", int'(bus.state), 2);
    ticks = 0;
    repeat (10) begin
      step();
      ticks += int'(bus.count_up_sec);
    end
    check("pause_no_ticks", ticks, 0);
    press(1'b1, 1'b0, 1'b0);
    check("resume_state", int'(bus.state), 1);
    wait_tick(n);
    check("resume_tick", n, 2);

    repeat (3) step();
    press(1'b1, 1'b0, 1'b0);
    check("pause_edge_state", int'(bus.state), 2);
    check("pause_edge_tick", int'(bus.count_up_sec), 1);

    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    check("reset_in_run", int'(bus.state), 1);
    check("reset_in_run_rc", int'(bus.rst_counters), 0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b1, 1'b0);
    check("rst_prio_state", int'(bus.state), 0);
    check("rst_counters_hi", int'(bus.rst_counters), 1);
    check("rst_stop", int'(bus.stop), 1);
    step();
    check("rst_counters_lo", int'(bus.rst_counters), 0);

    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    check("lap_state", int'(bus.state), 3);
    check("lap_hold", int'(bus.disp_hold), 1);
    wait_tick(n);
    check("lap_ticks", int'(n > 0 && n <= TD), 1);
    press(1'b0, 1'b0, 1'b1);
    check("lap_exit_state", int'(bus.state), 1);
    check("lap_exit_hold", int'(bus.disp_hold), 0);
    press(1'b0, 1'b0, 1'b1);
    press(1'b1, 1'b0, 1'b0);
    check("lap_pause_state", int'(bus.state), 2);
    check("lap_pause_hold", int'(bus.disp_hold), 0);

    press(1'b1, 1'b0, 1'b0);
    repeat (6) step();
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_outs",
          int'({bus.state, bus.stop, bus.disp_hold, bus.rst_counters, bus.count_up_sec}), 8);
    step();
    step();
    rst_n = 1'b1;
    press(1'b1, 1'b0, 1'b0);
    wait_tick(n);
    check("post_rst_first_tick", n, 4);

    repeat (3000) begin
      bus.btn_start_stop = ($urandom_range(0, 5) == 0);
      bus.btn_reset      = ($urandom_range(0, 5) == 0);
      bus.btn_lap        = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0:       bus.sec_val = 8'd58;
        1, 2:    bus.sec_val = 8'd59;
        default: bus.sec_val = 8'($urandom_range(0, 59));
      endcase
      bus.min_val = ($urandom_range(0, 1) == 0) ? 8'd59 : 8'($urandom_range(0, 59));
      if ($urandom_range(0, 399) == 0) begin
        #3 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
